// File: rtl/launcher_pkg.sv
// Shared types for the kernel launch sequencer: FSM state encoding and the
// launch descriptor carried through the request FIFO.
package launcher_pkg;

  localparam int DCR_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CONFIG,
    RUN,
    REPORT
  } launcher_state_t;

  typedef struct packed {
    logic [DCR_BITS-1:0] thread_count;
  } launch_t;

endpackage

// File: rtl/launch_fifo.sv
// Single-clock FIFO for launch requests. Pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter.
module launch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == FULL_LEVEL);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // A push while full is refused even if a pop lands on the same edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/kernel_launcher.sv
// Launch sequencer in front of the GPU: per queued launch it pulses GPU reset,
// writes the DCR, holds start until done (or timeout) and reports a record.
module kernel_launcher
  import launcher_pkg::*;
#(
  parameter int QUEUE_DEPTH      = 4,
  parameter int CYCLE_COUNT_BITS = 24,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          launch_valid,
  output logic                          launch_ready,
  input  logic [DCR_BITS-1:0]           launch_thread_count,
  output logic                          gpu_reset,
  output logic                          device_control_write_enable,
  output logic [DCR_BITS-1:0]           device_control_data,
  output logic                          start,
  input  logic                          done,
  output logic                          complete_valid,
  input  logic                          complete_ready,
  output logic [DCR_BITS-1:0]           complete_thread_count,
  output logic [CYCLE_COUNT_BITS-1:0]   complete_cycles,
  output logic                          complete_timeout,
  output logic                          busy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_level
);

  localparam logic [CYCLE_COUNT_BITS-1:0] ONE         = CYCLE_COUNT_BITS'(1);
  localparam logic [CYCLE_COUNT_BITS-1:0] TIMEOUT_VAL = CYCLE_COUNT_BITS'(TIMEOUT_CYCLES);
  localparam bit                          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  launcher_state_t             r_state;
  launcher_state_t             w_next_state;
  logic [DCR_BITS-1:0]         r_cur_count;
  logic [CYCLE_COUNT_BITS-1:0] r_cycles;
  logic                        r_timeout;

  launch_t w_tail;
  launch_t w_head;
  logic    w_empty;
  logic    w_full;
  logic    w_pop;
  logic    w_done_eff;
  logic    w_timeout_hit;

  assign w_tail.thread_count = launch_thread_count;

  launch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(launch_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (launch_valid),
    .i_data  (w_tail),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (queue_level)
  );

  assign launch_ready = !w_full;

  // The counter reads 1 only in the first RUN cycle, where done may be stale.
  assign w_done_eff = done && (r_cycles != ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    w_next_state                = r_state;
    w_pop                       = 1'b0;
    w_timeout_hit               = 1'b0;
    gpu_reset                   = 1'b0;
    device_control_write_enable = 1'b0;
    start                       = 1'b0;
    complete_valid              = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = (w_head.thread_count != '0) ? CLEAR : REPORT;
        end
      end
      CLEAR: begin
        gpu_reset    = 1'b1;
        w_next_state = CONFIG;
      end
      CONFIG: begin
        device_control_write_enable = 1'b1;
        w_next_state                = RUN;
      end
      RUN: begin
        start = 1'b1;
        if (w_done_eff) begin
          w_next_state = REPORT;
        end else if (TIMEOUT_EN && (r_cycles == TIMEOUT_VAL)) begin
          w_next_state  = REPORT;
          w_timeout_hit = 1'b1;
        end
      end
      REPORT: begin
        complete_valid = 1'b1;
        if (complete_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_count <= '0;
      r_cycles    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_count <= w_head.thread_count;
        r_cycles    <= '0;
        r_timeout   <= 1'b0;
      end
      if (r_state == CONFIG) begin
        r_cycles <= ONE;
      end else if (r_state == RUN && w_next_state == RUN && r_cycles != '1) begin
        r_cycles <= r_cycles + ONE;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign device_control_data   = device_control_write_enable ? r_cur_count : '0;
  assign complete_thread_count = r_cur_count;
  assign complete_cycles       = r_cycles;
  assign complete_timeout      = r_timeout;
  assign busy                  = (r_state != IDLE);

endmodule

// File: doc/kernel_launcher.md
# kernel_launcher

Host-side launch sequencer directly upstream of the `gpu` top level. It queues kernel launch requests, each a thread count, and runs them one at a time. For each launch it pulses the GPU's synchronous reset, writes the device control register, holds `start` until `done`, and then reports a completion record with the measured cycle count or a timeout flag. It is the only driver of the GPU's `reset`, `start` and device-control-register inputs.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: launch FIFO entries; power of two, ≥2.
- `CYCLE_COUNT_BITS`, default 24: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, default 0: run-cycle limit; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `launch_valid` in 1: launch request present.
- `launch_ready` out 1: FIFO not full.
- `launch_thread_count` in 8: total threads for the launch.
- `gpu_reset` out 1: drives GPU `reset`.
- `device_control_write_enable` out 1: drives the GPU DCR write enable.
- `device_control_data` out 8: drives the GPU DCR data.
- `start` out 1: drives GPU `start`.
- `done` in 1: from GPU `done`.
- `complete_valid` out 1: completion record valid.
- `complete_ready` in 1: consumer accepts the record.
- `complete_thread_count` out 8: echoed thread count.
- `complete_cycles` out CYCLE_COUNT_BITS: number of cycles `start` was high.
- `complete_timeout` out 1: the run was aborted by timeout.
- `busy` out 1: FSM not in IDLE.
- `queue_level` out $clog2(QUEUE_DEPTH)+1: FIFO occupancy.

## Operation
- The FIFO push condition is `launch_valid && launch_ready`. `launch_ready = (level != QUEUE_DEPTH)`. There is no bypass: a push while full is refused even if a pop happens in the same cycle.
- The FIFO pops only in IDLE when it is non-empty. The popped count is latched into `cur_count`.
- FSM states: IDLE, CLEAR, CONFIG, RUN, REPORT.
- IDLE → CLEAR on pop when `cur_count != 0`.
- IDLE → REPORT on pop when `cur_count == 0`. Zero-thread launches never touch the GPU; they report with cycles = 0 and timeout = 0.
- CLEAR (1 cycle): `gpu_reset = 1`. This clears any stale `done` and the DCR. → CONFIG.
- CONFIG (1 cycle): `device_control_write_enable = 1`, `device_control_data = cur_count`. → RUN.
- RUN: `start = 1`. The counter starts at 1 in the first RUN cycle and increments each cycle, saturating at all-ones. `done` is ignored in the first RUN cycle (settle).
  - From the second RUN cycle onward, `done == 1` → REPORT.
  - If `TIMEOUT_CYCLES != 0` and the counter equals `TIMEOUT_CYCLES` with `done == 0`, the FSM goes to REPORT with the timeout flag set. The next launch's CLEAR resets the hung GPU.
  - If `done` and the timeout coincide, `done` wins and the timeout flag stays 0.
- REPORT: `complete_valid = 1`. The record fields are stable until `complete_ready`. On `complete_valid && complete_ready` → IDLE.
- Asynchronous reset mid-operation: FIFO emptied, FSM → IDLE, counter cleared, the pending record dropped. Every output takes its reset value at once.
- Output reset values: `launch_ready` = 1, `queue_level` = 0; all other outputs 0.

## Timing
- All outputs except `launch_ready` are registered or decoded from registered state only. There are no combinational paths from inputs to outputs other than `launch_ready`, which depends only on `level`.
- Push at edge T, with the FIFO previously empty and the FSM in IDLE:
  - cycle T+1: IDLE sees the entry and pops;
  - T+2: CLEAR;
  - T+3: CONFIG;
  - T+4: first RUN cycle.
- If `done` is first sampled high in RUN cycle N (N ≥ 2):
  - `start` is high for N cycles;
  - `complete_valid` rises the next cycle with `complete_cycles = N`.
- Back-to-back launches: IDLE lasts one cycle after the REPORT handshake, so the next CLEAR follows two cycles after the accepting edge.
- `queue_level` updates on the edge of push/pop; a simultaneous push and pop leaves it unchanged.

## Structure
- Package `launcher_pkg` holds:
  - the `launcher_state_t` enum (IDLE, CLEAR, CONFIG, RUN, REPORT);
  - the `launch_t` struct (thread count);
  - the localparam `DCR_BITS = 8`.
- Sub-module `launch_fifo` is a synchronous single-clock FIFO, parameterised by depth and width, with pointers that carry an extra wrap bit. The top level holds the FSM, the counter and the record registers.

## Test plan
- Single launch: reset; push count 8; model `done` high 5 cycles after `start` rises → `gpu_reset` at T+2, DCR write of 0x08 at T+3, `complete_cycles` = 6, `complete_timeout` = 0.
- Queue full: hold `complete_ready` = 0 and push 6 launches with QUEUE_DEPTH = 4 → `launch_ready` falls after 5 accepts (4 queued + 1 in flight), `queue_level` = 4; releasing completions drains them in order with counts echoed.
- Zero threads: push 0 → no `gpu_reset`/DCR write/`start` activity; record with cycles = 0 one cycle after the pop.
- Timeout: TIMEOUT_CYCLES = 10, `done` tied 0 → `start` high exactly 10 cycles, `complete_timeout` = 1, `complete_cycles` = 10; the next launch begins with a CLEAR pulse.
- Stale `done`: `done` held high entering RUN → ignored in RUN cycle 1, so `complete_cycles` = 2.
- Reset mid-RUN: assert `reset` asynchronously → `start` and `busy` drop immediately, `queue_level` = 0, no `complete_valid` afterwards.
